// File: rtl/rx_pkg.sv
// Shared constants for the serial-to-parallel receive path: byte width,
// comma pattern, lock/idle thresholds and FSM state codes.
package rx_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] COMMA_DEF = 8'hBC;

    localparam int unsigned LOCK_COUNT_DEF = 4;
    localparam int unsigned IDLE_COUNT_DEF = 4;

    // Code 2'd3 is unused; the FSM treats it as HUNT.
    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/comma_shift_detect.sv
// Serial shift register: presents the current 8-bit window (MSB first,
// newest bit in the LSB) and flags when that window equals the comma.
module comma_shift_detect
    import rx_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COMMA = COMMA_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_bit,
    output logic [BYTE_W-1:0] o_word_c,
    output logic              o_is_comma_c
);

    // Only the 7 older bits need storage; the newest bit is the live input.
    logic [BYTE_W-2:0] r_sr;

    assign o_word_c     = {r_sr, i_bit};
    assign o_is_comma_c = (o_word_c == COMMA);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr <= '0;
        end else begin
            r_sr <= o_word_c[BYTE_W-2:0];
        end
    end

endmodule

// File: rtl/serial_paralelo_rx.sv
// Receive deserializer: hunts for the comma, locks after a run of aligned
// commas, then recovers bytes and reports idle runs on the locked link.
module serial_paralelo_rx
    import rx_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COMMA      = COMMA_DEF,
    parameter int unsigned       LOCK_COUNT = LOCK_COUNT_DEF,
    parameter int unsigned       IDLE_COUNT = IDLE_COUNT_DEF
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              data_in,
    output logic [BYTE_W-1:0] data_out,
    output logic              valid_out,
    output logic              active_out,
    output logic              idle_out,
    output logic              byte_strobe
);

    localparam int unsigned BCW        = $clog2(BYTE_W);
    localparam int unsigned CW         = $clog2(LOCK_COUNT) + 1;
    localparam int unsigned IW         = $clog2(IDLE_COUNT) + 1;
    localparam int unsigned ENTRY_IDLE = min_u(LOCK_COUNT, IDLE_COUNT);

    localparam logic [CW-1:0]  LOCK_C         = CW'(LOCK_COUNT);
    localparam logic [IW-1:0]  IDLE_C         = IW'(IDLE_COUNT);
    localparam logic [IW-1:0]  ENTRY_IDLE_C   = IW'(ENTRY_IDLE);
    localparam logic           ENTRY_IDLE_OUT = (ENTRY_IDLE >= IDLE_COUNT);
    localparam logic [BCW-1:0] LAST_BIT       = BCW'(BYTE_W - 1);

    logic [1:0]        r_state;
    logic [BCW-1:0]    r_bit_cnt;
    logic [CW-1:0]     r_comma_cnt;
    logic [IW-1:0]     r_idle_cnt;
    logic [BYTE_W-1:0] r_data;
    logic              r_valid;
    logic              r_active;
    logic              r_idle;
    logic              r_strobe;

    logic [1:0]        w_nxt_state;
    logic [BCW-1:0]    w_nxt_bit_cnt;
    logic [CW-1:0]     w_nxt_comma_cnt;
    logic [IW-1:0]     w_nxt_idle_cnt;
    logic [BYTE_W-1:0] w_nxt_data;
    logic              w_nxt_valid;
    logic              w_nxt_active;
    logic              w_nxt_idle;
    logic              w_nxt_strobe;
    logic              w_enter_active;

    logic [BYTE_W-1:0] w_word;
    logic              w_is_comma;
    logic              w_boundary;
    logic [IW-1:0]     w_idle_inc;

    comma_shift_detect #(
        .COMMA (COMMA)
    ) u_detect (
        .i_clk        (clk_32f),
        .i_rst_n      (reset),
        .i_bit        (data_in),
        .o_word_c     (w_word),
        .o_is_comma_c (w_is_comma)
    );

    assign w_boundary = (r_bit_cnt == LAST_BIT);
    assign w_idle_inc = (r_idle_cnt >= IDLE_C) ? r_idle_cnt : r_idle_cnt + IW'(1);

    // Next-state and next-output decode.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_bit_cnt   = r_bit_cnt;
        w_nxt_comma_cnt = r_comma_cnt;
        w_nxt_idle_cnt  = r_idle_cnt;
        w_nxt_data      = r_data;
        w_nxt_valid     = r_valid;
        w_nxt_active    = r_active;
        w_nxt_idle      = r_idle;
        w_nxt_strobe    = 1'b0;
        w_enter_active  = 1'b0;

        case (r_state)
            ST_SYNC: begin
                w_nxt_bit_cnt = r_bit_cnt + BCW'(1);
                if (w_boundary) begin
                    w_nxt_strobe = 1'b1;
                    if (w_is_comma) begin
                        w_nxt_comma_cnt = r_comma_cnt + CW'(1);
                        w_enter_active  = (w_nxt_comma_cnt >= LOCK_C);
                    end else begin
                        w_nxt_state     = ST_HUNT;
                        w_nxt_comma_cnt = '0;
                        w_nxt_bit_cnt   = '0;
                    end
                end
            end

            ST_ACTIVE: begin
                w_nxt_bit_cnt = r_bit_cnt + BCW'(1);
                if (w_boundary) begin
                    w_nxt_strobe = 1'b1;
                    if (w_is_comma) begin
                        w_nxt_valid    = 1'b0;
                        w_nxt_idle_cnt = w_idle_inc;
                        w_nxt_idle     = (w_idle_inc >= IDLE_C);
                    end else begin
                        w_nxt_data     = w_word;
                        w_nxt_valid    = 1'b1;
                        w_nxt_idle_cnt = '0;
                        w_nxt_idle     = 1'b0;
                    end
                end
            end

            default: begin
                // HUNT: bit-by-bit search; a match fixes the byte phase.
                w_nxt_bit_cnt = '0;
                if (w_is_comma) begin
                    w_nxt_comma_cnt = CW'(1);
                    if (LOCK_COUNT <= 1) begin
                        w_enter_active = 1'b1;
                    end else begin
                        w_nxt_state = ST_SYNC;
                    end
                end
            end
        endcase

        if (w_enter_active) begin
            w_nxt_state    = ST_ACTIVE;
            w_nxt_active   = 1'b1;
            w_nxt_idle_cnt = ENTRY_IDLE_C;
            w_nxt_idle     = ENTRY_IDLE_OUT;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_HUNT;
            r_bit_cnt   <= '0;
            r_comma_cnt <= '0;
            r_idle_cnt  <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_active    <= 1'b0;
            r_idle      <= 1'b0;
            r_strobe    <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_bit_cnt   <= w_nxt_bit_cnt;
            r_comma_cnt <= w_nxt_comma_cnt;
            r_idle_cnt  <= w_nxt_idle_cnt;
            r_data      <= w_nxt_data;
            r_valid     <= w_nxt_valid;
            r_active    <= w_nxt_active;
            r_idle      <= w_nxt_idle;
            r_strobe    <= w_nxt_strobe;
        end
    end

    assign data_out    = r_data;
    assign valid_out   = r_valid;
    assign active_out  = r_active;
    assign idle_out    = r_idle;
    assign byte_strobe = r_strobe;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Self-checking bench for serial_paralelo_rx: directed lock/data/idle/reset
// sequences plus random bit streams checked against a stream-level model.
module tb_serial_paralelo_rx;

    localparam logic [7:0] BC   = 8'hBC;
    localparam int         LOCK = 4;
    localparam int         IDLE = 4;
    localparam int         MAXB = 1024;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active_out;
    logic       idle_out;
    logic       byte_strobe;

    int n_cmp  = 0;
    int n_fail = 0;

    logic        sb    [MAXB];
    logic [11:0] exp_o [MAXB];
    int          nb;

    typedef struct {
        logic [7:0]  din;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs [10];

    serial_paralelo_rx dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .active_out  (active_out),
        .idle_out    (idle_out),
        .byte_strobe (byte_strobe)
    );

    always #5 clk_32f = ~clk_32f;

    function automatic logic [11:0] pk(input logic s, input logic a, input logic i,
                                       input logic v, input logic [7:0] d);
        return {s, a, i, v, d};
    endfunction

    function automatic logic [11:0] outs();
        return {byte_strobe, active_out, idle_out, valid_out, data_out};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic do_reset();
        data_in = 1'b0;
        reset   = 1'b0;
        @(posedge clk_32f);
        #1;
        reset = 1'b1;
    endtask

    function automatic void push_bit(input logic b);
        if (nb < MAXB) begin
            sb[nb] = b;
            nb++;
        end
    endfunction

    function automatic void push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) push_bit(b[i]);
    endfunction

    // Stream-level reference: a comma seen in hunt fixes a byte grid (anchor);
    // only windows on that grid are evaluated afterwards.
    function automatic void run_model();
        int         mode    = 0;
        int         anchor  = 0;
        int         run     = 0;
        int         idlerun = 0;
        logic [7:0] d       = 8'h00;
        logic       v       = 1'b0;
        logic       act     = 1'b0;
        logic       s;
        logic [7:0] w;
        for (int t = 0; t < nb; t++) begin
            w = 8'h00;
            for (int k = 7; k >= 0; k--) begin
                if (t - k >= 0) w = {w[6:0], sb[t-k]};
                else            w = {w[6:0], 1'b0};
            end
            s = 1'b0;
            if (mode == 0) begin
                if (w == BC) begin
                    anchor = t;
                    run    = 1;
                    if (run >= LOCK) begin
                        mode = 2; act = 1'b1; idlerun = (LOCK < IDLE) ? LOCK : IDLE;
                    end else begin
                        mode = 1;
                    end
                end
            end else if (((t - anchor) % 8) == 0) begin
                s = 1'b1;
                if (mode == 1) begin
                    if (w == BC) begin
                        run++;
                        if (run >= LOCK) begin
                            mode = 2; act = 1'b1; idlerun = (LOCK < IDLE) ? LOCK : IDLE;
                        end
                    end else begin
                        mode = 0;
                        run  = 0;
                    end
                end else begin
                    if (w == BC) begin
                        v = 1'b0;
                        if (idlerun < IDLE) idlerun++;
                    end else begin
                        d = w;
                        v = 1'b1;
                        idlerun = 0;
                    end
                end
            end
            exp_o[t] = {s, act, (act && idlerun >= IDLE), v, d};
        end
    endfunction

    initial begin
        int          nstrobe;
        logic [11:0] prev;
        logic [7:0]  rb;
        int          r;

        vecs[0] = '{8'hA5, pk(1, 1, 0, 1, 8'hA5)};
        vecs[1] = '{8'h0F, pk(1, 1, 0, 1, 8'h0F)};
        vecs[2] = '{BC,    pk(1, 1, 0, 0, 8'h0F)};
        vecs[3] = '{8'hFF, pk(1, 1, 0, 1, 8'hFF)};
        vecs[4] = '{BC,    pk(1, 1, 0, 0, 8'hFF)};
        vecs[5] = '{BC,    pk(1, 1, 0, 0, 8'hFF)};
        vecs[6] = '{BC,    pk(1, 1, 0, 0, 8'hFF)};
        vecs[7] = '{BC,    pk(1, 1, 1, 0, 8'hFF)};
        vecs[8] = '{8'h11, pk(1, 1, 0, 1, 8'h11)};
        vecs[9] = '{BC,    pk(1, 1, 0, 0, 8'h11)};

        // Reset held with random input: everything stays cleared.
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_in = 1'($urandom_range(0, 1));
            @(posedge clk_32f);
            #1;
            check("reset_hold", 32'(outs()), 32'(pk(0, 0, 0, 0, 8'h00)));
        end
        reset = 1'b1;

        // Constant zero never matches the comma: no strobes, no lock.
        nstrobe = 0;
        for (int i = 0; i < 64; i++) begin
            send_bit(1'b0);
            if (byte_strobe) nstrobe++;
        end
        check("zeros_strobes", 32'(nstrobe), 32'd0);
        check("zeros_outs", 32'(outs()), 32'(pk(0, 0, 0, 0, 8'h00)));

        // Lock acquisition after one garbage bit.
        do_reset();
        send_bit(1'b1);
        send_byte(BC);
        check("lock_bc1", 32'(outs()), 32'(pk(0, 0, 0, 0, 8'h00)));
        send_byte(BC);
        check("lock_bc2", 32'(outs()), 32'(pk(1, 0, 0, 0, 8'h00)));
        send_byte(BC);
        check("lock_bc3", 32'(outs()), 32'(pk(1, 0, 0, 0, 8'h00)));
        send_byte(BC);
        check("lock_bc4", 32'(outs()), 32'(pk(1, 1, 1, 0, 8'h00)));

        // Table: data recovery and idle detection on the locked link.
        prev = pk(1, 1, 1, 0, 8'h00);
        for (int n = 0; n < 10; n++) begin
            for (int i = 7; i >= 0; i--) begin
                send_bit(vecs[n].din[i]);
                if (i == 7) check($sformatf("vec%0d_hold", n), 32'(outs()), 32'({1'b0, prev[10:0]}));
            end
            check($sformatf("vec%0d", n), 32'(outs()), 32'(vecs[n].exp));
            prev = vecs[n].exp;
        end

        // Async reset in the middle of a byte while locked.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        #4;
        reset = 1'b0;
        #1;
        check("async_rst", 32'(outs()), 32'(pk(0, 0, 0, 0, 8'h00)));
        @(posedge clk_32f);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) send_byte(BC);
        check("relock_bc3", 32'(outs()), 32'(pk(1, 0, 0, 0, 8'h00)));
        send_byte(BC);
        check("relock_bc4", 32'(outs()), 32'(pk(1, 1, 1, 0, 8'h00)));

        // Failed sync: a non-comma on the grid drops back to hunt.
        do_reset();
        send_byte(BC);
        send_byte(BC);
        send_byte(8'h3C);
        check("fail_3c", 32'(outs()), 32'(pk(1, 0, 0, 0, 8'h00)));
        send_byte(BC);
        check("fail_bc1", 32'(outs()), 32'(pk(0, 0, 0, 0, 8'h00)));
        send_byte(BC);
        send_byte(BC);
        check("fail_bc3", 32'(outs()), 32'(pk(1, 0, 0, 0, 8'h00)));
        send_byte(BC);
        check("fail_bc4", 32'(outs()), 32'(pk(1, 1, 1, 0, 8'h00)));

        // Random streams: garbage, optional lock preamble, data/comma mix with slips.
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            nb = 0;
            r = int'($urandom_range(0, 12));
            for (int i = 0; i < r; i++) push_bit(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) != 0) for (int i = 0; i < 4; i++) push_byte(BC);
            for (int n = 0; n < 40; n++) begin
                r = int'($urandom_range(0, 9));
                if (r < 4) begin
                    push_byte(BC);
                end else begin
                    if (r == 4) begin
                        for (int i = 0; i < int'($urandom_range(1, 3)); i++)
                            push_bit(1'($urandom_range(0, 1)));
                    end
                    rb = 8'($urandom);
                    push_byte(rb);
                end
            end
            run_model();
            for (int t = 0; t < nb; t++) begin
                send_bit(sb[t]);
                check($sformatf("rand_s%0d_t%0d", seg, t), 32'(outs()), 32'(exp_o[t]));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
